// File: rtl/msk_pkg.sv
// Shared types and helpers for the masked share deserializer: state encoding,
// index-width helper and the standard sharing-bus lane index (bit i, share j).
package msk_pkg;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   // $clog2 with a floor of 1 so a single-share build still gets a 1-bit index
   function automatic int clog2_min1(input int value);
      int w;
      w = $clog2(value);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int lane_idx(input int i, input int j, input int d);
      return i * d + j;
   endfunction

endpackage

// File: rtl/msk_share_lane.sv
// One share index worth of storage: a count-bit enabled register, cleared by
// synchronous reset. One instance per share keeps the shares physically apart.
module msk_share_lane #(
   parameter int count = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [count-1:0] d_in,
   output logic [count-1:0] q
);

   // Lane register: holds its share until the next write to this index
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d_in;
      end
   end

endmodule

// File: rtl/msk_share_deser.sv
// Serial-to-parallel loader for masked data: one share per handshake, all d shares
// presented on a standard sharing bus. Optional ring refresh: MSK_DESER_REFRESH_EN.
module msk_share_deser
   import msk_pkg::*;
#(
   parameter int d     = 2,
   parameter int count = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [count-1:0]   in_share,
   input  logic               in_valid,
   output logic               in_ready,
`ifdef MSK_DESER_REFRESH_EN
   input  logic [count*d-1:0] rnd,
`endif
   output logic [count*d-1:0] out,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int IW = clog2_min1(d);
   localparam logic [IW-1:0] LAST_IDX = IW'(d - 1);

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   share_idx;
   logic [IW-1:0]   share_idx_nxt;
   logic            accept;
   logic            last;

   assign accept = in_valid & in_ready;
   assign last   = accept && (share_idx == LAST_IDX);

   // In FULL the single buffer frees up exactly when downstream consumes it
   always_comb begin
      state_nxt     = state;
      share_idx_nxt = share_idx;
      in_ready      = (state == FILL) | out_ready;
      out_valid     = (state == FULL);
      if (accept) begin
         if (share_idx == LAST_IDX) begin
            state_nxt     = FULL;
            share_idx_nxt = '0;
         end else begin
            state_nxt     = FILL;
            share_idx_nxt = share_idx + IW'(1);
         end
      end else if ((state == FULL) && out_ready) begin
         state_nxt     = FILL;
         share_idx_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         share_idx <= '0;
      end else begin
         state     <= state_nxt;
         share_idx <= share_idx_nxt;
      end
   end

   for (genvar j = 0; j < d; j++) begin : g_lane
      logic [count-1:0] q;
      logic [count-1:0] lane_d;
      logic             lane_en;
      logic             sel;

      assign sel = accept && (share_idx == IW'(j));

`ifdef MSK_DESER_REFRESH_EN
      // Ring refresh touches only this lane and randomness, never a neighbouring share
      logic [count-1:0] mask;
      for (genvar i = 0; i < count; i++) begin : g_mask
         assign mask[i] = rnd[lane_idx(i, j, d)] ^ rnd[lane_idx(i, (j + d - 1) % d, d)];
      end
      assign lane_en = sel | last;
      assign lane_d  = (sel ? in_share : q) ^ (last ? mask : '0);
`else
      assign lane_en = sel;
      assign lane_d  = in_share;
`endif

      msk_share_lane #(
         .count(count)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .en   (lane_en),
         .d_in (lane_d),
         .q    (q)
      );

      for (genvar i = 0; i < count; i++) begin : g_out
         assign out[lane_idx(i, j, d)] = q[i];
      end
   end

endmodule

// File: tb/tb_msk_share_deser.sv
// Bench for msk_share_deser: four configurations checked against a share-queue
// reference model; the MSK_DESER_REFRESH_EN build also checks the refresh invariant.
module tb_msk_share_deser;

   localparam int DD[4] = '{2, 3, 1, 3};
   localparam int CC[4] = '{4, 1, 8, 4};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0]  inShare[4];
   logic        inValid[4];
   logic        outReady[4];
   logic        inReady[4];
   logic        outValid[4];
   logic [15:0] outBus[4];

   logic        r0, r1, r2, r3;
   logic        v0, v1, v2, v3;
   logic [7:0]  o0;
   logic [2:0]  o1;
   logic [7:0]  o2;
   logic [11:0] o3;

   assign inReady[0] = r0;
   assign inReady[1] = r1;
   assign inReady[2] = r2;
   assign inReady[3] = r3;
   assign outValid[0] = v0;
   assign outValid[1] = v1;
   assign outValid[2] = v2;
   assign outValid[3] = v3;
   assign outBus[0] = 16'(o0);
   assign outBus[1] = 16'(o1);
   assign outBus[2] = 16'(o2);
   assign outBus[3] = 16'(o3);

`ifdef MSK_DESER_REFRESH_EN
   logic [11:0] rnd3 = '0;
`endif

   msk_share_deser #(.d(2), .count(4)) u_dut0 (
      .clk(clk), .rst(rst), .in_share(inShare[0][3:0]), .in_valid(inValid[0]), .in_ready(r0),
`ifdef MSK_DESER_REFRESH_EN
      .rnd(8'h00),
`endif
      .out(o0), .out_valid(v0), .out_ready(outReady[0]));

   msk_share_deser #(.d(3), .count(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_share(inShare[1][0:0]), .in_valid(inValid[1]), .in_ready(r1),
`ifdef MSK_DESER_REFRESH_EN
      .rnd(3'b000),
`endif
      .out(o1), .out_valid(v1), .out_ready(outReady[1]));

   msk_share_deser #(.d(1), .count(8)) u_dut2 (
      .clk(clk), .rst(rst), .in_share(inShare[2]), .in_valid(inValid[2]), .in_ready(r2),
`ifdef MSK_DESER_REFRESH_EN
      .rnd(8'h00),
`endif
      .out(o2), .out_valid(v2), .out_ready(outReady[2]));

   msk_share_deser #(.d(3), .count(4)) u_dut3 (
      .clk(clk), .rst(rst), .in_share(inShare[3][3:0]), .in_valid(inValid[3]), .in_ready(r3),
`ifdef MSK_DESER_REFRESH_EN
      .rnd(rnd3),
`endif
      .out(o3), .out_valid(v3), .out_ready(outReady[3]));

   int checks   = 0;
   int failures = 0;
   int consumed[4];

   // Reference model: shares collected so far plus the sharing currently on offer
   int          mCnt[4];
   logic [7:0]  mShares[4][3];
   bit          mFull[4];
   logic [15:0] mOut[4];
   logic [7:0]  mPlain[4];

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] unmask(input int k, input logic [15:0] v);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < CC[k]; i++)
         for (int j = 0; j < DD[k]; j++)
            r[i] = r[i] ^ v[i * DD[k] + j];
      return r;
   endfunction

   function automatic logic [15:0] assemble(input int k);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < CC[k]; i++)
         for (int j = 0; j < DD[k]; j++)
            r[i * DD[k] + j] = mShares[k][j][i];
      return r;
   endfunction

   task automatic resetModels();
      for (int k = 0; k < 4; k++) begin
         mCnt[k]  = 0;
         mFull[k] = 1'b0;
         consumed[k] = 0;
      end
   endtask

   task automatic applyReset();
      for (int k = 0; k < 4; k++) begin
         inValid[k] = 1'b0;
         inShare[k] = '0;
         outReady[k] = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      resetModels();
   endtask

   // One clock of traffic on DUT k; entered and left 1 time unit after a rising edge
   task automatic applyStimulus(input int k, input bit vld, input logic [7:0] sh, input bit ordy);
      bit         expReady;
      logic [7:0] msk;
      logic [7:0] s;
      msk = 8'((1 << CC[k]) - 1);
      s   = sh & msk;
      inValid[k]  = vld;
      inShare[k]  = s;
      outReady[k] = ordy;
`ifdef MSK_DESER_REFRESH_EN
      if (k == 3) rnd3 = 12'($urandom);
`endif
      #2;
      expReady = !mFull[k] || ordy;
      checkOutput($sformatf("k%0d out_valid", k), 64'(outValid[k]), 64'(mFull[k]));
      checkOutput($sformatf("k%0d in_ready", k), 64'(inReady[k]), 64'(expReady));
      if (mFull[k]) begin
`ifdef MSK_DESER_REFRESH_EN
         if (k == 3)
            checkOutput("k3 refreshed xor", 64'(unmask(k, outBus[k])), 64'(mPlain[k]));
         else
            checkOutput($sformatf("k%0d out", k), 64'(outBus[k]), 64'(mOut[k]));
`else
         checkOutput($sformatf("k%0d out", k), 64'(outBus[k]), 64'(mOut[k]));
`endif
      end
      if (outValid[k] && ordy) consumed[k]++;
      if (mFull[k] && ordy) mFull[k] = 1'b0;
      if (vld && expReady) begin
         mShares[k][mCnt[k]] = s;
         mCnt[k]++;
         if (mCnt[k] == DD[k]) begin
            mOut[k]   = assemble(k);
            mPlain[k] = '0;
            for (int j = 0; j < DD[k]; j++) mPlain[k] = mPlain[k] ^ mShares[k][j];
            mFull[k]  = 1'b1;
            mCnt[k]   = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      inValid[k]  = 1'b0;
      outReady[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         inValid[k] = 1'b0;
         inShare[k] = '0;
         outReady[k] = 1'b0;
      end
      resetModels();
      applyReset();

      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("k%0d reset out_valid", k), 64'(outValid[k]), 64'd0);
         checkOutput($sformatf("k%0d reset in_ready", k), 64'(inReady[k]), 64'd1);
         checkOutput($sformatf("k%0d reset out", k), 64'(outBus[k]), 64'd0);
      end

      // d=2 count=4 directed sharing 0xA, 0x5
      applyStimulus(0, 1'b1, 8'hA, 1'b1);
      applyStimulus(0, 1'b1, 8'h5, 1'b1);
      checkOutput("k0 directed out_valid", 64'(outValid[0]), 64'd1);
      checkOutput("k0 directed out", 64'(outBus[0]), 64'h66);
      checkOutput("k0 directed plain", 64'(unmask(0, outBus[0])), 64'hF);
      applyStimulus(0, 1'b0, 8'h0, 1'b1);
      idle(0);

      // d=3 count=1 stall: buffer held with in_share ignored
      for (int n = 0; n < 3; n++) applyStimulus(1, 1'b1, 8'($urandom), 1'b0);
      for (int n = 0; n < 10; n++) applyStimulus(1, 1'b1, 8'($urandom), 1'b0);
      applyStimulus(1, 1'b0, 8'h0, 1'b1);
      applyStimulus(1, 1'b0, 8'h0, 1'b0);
      idle(1);

      // d=2 back-to-back stream: one sharing every two cycles
      consumed[0] = 0;
      for (int n = 0; n < 20; n++) applyStimulus(0, 1'b1, 8'($urandom), 1'b1);
      applyStimulus(0, 1'b0, 8'h0, 1'b1);
      checkOutput("k0 stream sharings", 64'(consumed[0]), 64'd10);
      idle(0);

      // d=3 reset in the middle of a fill
      applyStimulus(1, 1'b1, 8'h1, 1'b0);
      applyStimulus(1, 1'b1, 8'h0, 1'b0);
      rst = 1'b1;
      inValid[1] = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      resetModels();
      checkOutput("k1 mid-fill reset out_valid", 64'(outValid[1]), 64'd0);
      checkOutput("k1 mid-fill reset out", 64'(outBus[1]), 64'd0);
      applyStimulus(1, 1'b1, 8'h1, 1'b0);
      applyStimulus(1, 1'b1, 8'h1, 1'b0);
      applyStimulus(1, 1'b1, 8'h0, 1'b0);
      checkOutput("k1 clean sharing", 64'(outBus[1]), 64'b011);
      applyStimulus(1, 1'b0, 8'h0, 1'b1);
      idle(1);

      // d=1 count=8: sustained one word per cycle
      consumed[2] = 0;
      for (int n = 0; n < 16; n++) applyStimulus(2, 1'b1, 8'($urandom), 1'b1);
      applyStimulus(2, 1'b0, 8'h0, 1'b1);
      checkOutput("k2 sustained words", 64'(consumed[2]), 64'd16);
      idle(2);

      // Randomized handshakes on every configuration
      for (int k = 0; k < 4; k++) begin
         for (int n = 0; n < 300; n++)
            applyStimulus(k, $urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 60);
         applyStimulus(k, 1'b0, 8'h0, 1'b1);
         idle(k);
      end

`ifdef MSK_DESER_REFRESH_EN
      // Refresh: XOR of refreshed shares per bit must equal XOR of the inputs
      consumed[3] = 0;
      for (int n = 0; n < 3100 && consumed[3] < 1000; n++)
         applyStimulus(3, 1'b1, 8'($urandom), 1'b1);
      checkOutput("k3 refreshed sharings", 64'(consumed[3] >= 1000), 64'd1);
      idle(3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
